ibuf_spram_ctrl: RTL and testbench

Sequencer that sits directly upstream of the input-buffer single-port RAM (spram), and also drains it.
- Accepts a burst of words on a valid/ready input stream and writes them into the RAM.
- Reads the words back in the same order onto a valid/ready output stream toward main_process.
- Hides the RAM's 1-cycle registered read latency behind a 2-entry output skid FIFO, so throughput is 1 word/cycle.

---
 rtl/ibuf_spram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ibuf_spram_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_spram_ctrl.sv
// ibuf_spram_ctrl: writes one burst from an input stream into the input-buffer
// single-port RAM, then reads it back in order onto an output stream. A
// 2-entry skid FIFO hides the RAM's registered read latency so the read side
// sustains one word per cycle.
module ibuf_spram_ctrl #(
    parameter int ASIZE = 10,
    parameter int DSIZE = 32
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_start,
    input  logic [ASIZE:0]   I_len,
    input  logic [DSIZE-1:0] I_sdata,
    input  logic             I_svalid,
    output logic             O_sready,
    output logic [DSIZE-1:0] O_mdata,
    input  logic             I_mready,
    output logic             O_mvalid,
    output logic             O_busy,
    output logic             O_done,
    output logic [ASIZE-1:0] O_ram_addr,
    output logic [DSIZE-1:0] O_ram_data,
    output logic             O_ram_wr,
    input  logic [DSIZE-1:0] I_ram_data
);

    localparam logic [ASIZE:0] DEPTH = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] ONE   = {{ASIZE{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [ASIZE:0]   wcnt, rcnt, len_r, len_clamp;
    logic [DSIZE-1:0] fifo_q0, fifo_q1;   // q0 is the head
    logic [1:0]       fifo_cnt;
    logic             inflight;           // a RAM read was issued last cycle
    logic             beat, last_wr, pop, push, issue, read_last;
    logic [2:0]       occ, credit;

    // Oversized requests are clamped so the burst never wraps the RAM.
    assign len_clamp = (I_len > DEPTH) ? DEPTH : I_len;

    assign beat      = (state == S_WRITE) & I_svalid;
    assign last_wr   = beat & (wcnt == len_r - ONE);

    // Read credit: words held plus the one in flight, less the one leaving,
    // must stay below the FIFO depth of 2.
    assign pop       = O_mvalid & I_mready;
    assign push      = inflight;
    assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign credit    = 3'd2 + {2'b00, pop};
    assign issue     = (state == S_READ) & (rcnt < len_r) & (occ < credit);
    assign read_last = pop & (fifo_cnt == 2'd1) & ~inflight & (rcnt == len_r);

    assign O_ram_data = I_sdata;
    assign O_mdata    = fifo_q0;

    // State register.
    always_ff @(posedge I_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (I_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE:  if (I_start) state_nxt = (len_clamp == '0) ? S_DONE : S_WRITE;
            S_WRITE: if (last_wr) state_nxt = S_READ;
            S_READ:  if (read_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: stream handshakes, RAM strobes and status.
    always_comb begin
        O_sready   = 1'b0;
        O_ram_wr   = 1'b0;
        O_ram_addr = '0;
        O_mvalid   = 1'b0;
        O_done     = 1'b0;
        O_busy     = (state != S_IDLE);
        case (state)
            S_WRITE: begin
                O_sready   = 1'b1;
                O_ram_wr   = I_svalid;
                O_ram_addr = wcnt[ASIZE-1:0];
            end
            S_READ: begin
                O_ram_addr = rcnt[ASIZE-1:0];
                O_mvalid   = (fifo_cnt != 2'd0);
            end
            S_DONE:  O_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: burst length, write/read counters, in-flight flag and skid FIFO.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            // NOTE: the FIFO data registers are reset because O_mdata must read
            // 0 out of reset; the external RAM contents are deliberately untouched.
            wcnt     <= '0;
            rcnt     <= '0;
            len_r    <= '0;
            fifo_cnt <= 2'd0;
            inflight <= 1'b0;
            fifo_q0  <= '0;
            fifo_q1  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (I_start) begin
                        len_r <= len_clamp;
                        wcnt  <= '0;
                    end
                end
                S_WRITE: begin
                    if (beat) wcnt <= wcnt + ONE;
                    if (last_wr) begin
                        rcnt     <= '0;
                        fifo_cnt <= 2'd0;
                        inflight <= 1'b0;
                    end
                end
                S_READ: begin
                    if (issue) rcnt <= rcnt + ONE;
                    inflight <= issue;
                    case ({push, pop})
                        2'b10: begin
                            if (fifo_cnt == 2'd0) fifo_q0 <= I_ram_data;
                            else                  fifo_q1 <= I_ram_data;
                            fifo_cnt <= fifo_cnt + 2'd1;
                        end
                        2'b01: begin
                            fifo_q0  <= fifo_q1;
                            fifo_cnt <= fifo_cnt - 2'd1;
                        end
                        2'b11: begin
                            if (fifo_cnt == 2'd1) begin
                                fifo_q0 <= I_ram_data;
                            end else begin
                                fifo_q0 <= fifo_q1;
                                fifo_q1 <= I_ram_data;
                            end
                        end
                        default: ;
                    endcase
                end
                default: begin
                    fifo_cnt <= 2'd0;
                    inflight <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibuf_spram_ctrl.sv
// Bench for ibuf_spram_ctrl with a 16-word RAM model: a table of bursts
// (length, input gaps, output backpressure, expected word count) plus hand
// sequences for a start pulse during WRITE and a reset in the middle of READ.
module tb_ibuf_spram_ctrl;

    localparam int ASIZE = 4;
    localparam int DSIZE = 32;

    logic             I_clk, I_rst, I_start, I_svalid, I_mready;
    logic [ASIZE:0]   I_len;
    logic [DSIZE-1:0] I_sdata, I_ram_data;
    logic             O_sready, O_mvalid, O_busy, O_done, O_ram_wr;
    logic [DSIZE-1:0] O_mdata, O_ram_data;
    logic [ASIZE-1:0] O_ram_addr;

    ibuf_spram_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_len(I_len),
        .I_sdata(I_sdata), .I_svalid(I_svalid), .O_sready(O_sready),
        .O_mdata(O_mdata), .I_mready(I_mready), .O_mvalid(O_mvalid),
        .O_busy(O_busy), .O_done(O_done), .O_ram_addr(O_ram_addr),
        .O_ram_data(O_ram_data), .O_ram_wr(O_ram_wr), .I_ram_data(I_ram_data)
    );

    // Single-port RAM model with a registered read port.
    logic [DSIZE-1:0] mem [0:(1<<ASIZE)-1];
    always @(posedge I_clk) begin
        if (O_ram_wr) mem[O_ram_addr] <= O_ram_data;
        I_ram_data <= mem[O_ram_addr];
    end

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int mready_pct = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
        I_mready = ($urandom_range(0, 99) < mready_pct);
    endtask

    // Monitor: logs writes, pops and timing at the falling edge; logs restart
    // whenever a start is seen in IDLE.
    int cyc = 0;
    int start_cyc, last_wr_cyc, first_mv_cyc, first_pop_cyc, last_pop_cyc, done_cyc;
    int done_cnt, bad_wr, bad_stall, bad_idle;
    logic [31:0] wr_addr_q[$], wr_data_q[$], pop_q[$];
    logic        stalled_prev = 1'b0;
    logic [31:0] stall_data;

    always @(negedge I_clk) begin
        cyc++;
        if (I_start && !O_busy && !I_rst) begin
            start_cyc = cyc; last_wr_cyc = -1; first_mv_cyc = -1;
            first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
            done_cnt = 0; bad_wr = 0; bad_stall = 0; bad_idle = 0;
            wr_addr_q.delete(); wr_data_q.delete(); pop_q.delete();
        end
        if (O_ram_wr) begin
            wr_addr_q.push_back(32'(O_ram_addr));
            wr_data_q.push_back(O_ram_data);
            last_wr_cyc = cyc;
            if (!I_svalid) bad_wr++;
        end
        if (O_mvalid && first_mv_cyc < 0) first_mv_cyc = cyc;
        if (O_mvalid && I_mready) begin
            pop_q.push_back(O_mdata);
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (stalled_prev && (!O_mvalid || O_mdata !== stall_data)) bad_stall++;
        stalled_prev = O_mvalid && !I_mready && !I_rst;
        stall_data   = O_mdata;
        if (O_done) begin done_cnt++; done_cyc = cyc; end
        if (!O_busy && (O_mvalid || O_sready)) bad_idle++;
    end

    typedef struct {
        int          len;      // I_len requested
        int          gap_max;  // max idle cycles before each input word (0 = none)
        int          pct;      // I_mready probability in percent
        logic [31:0] base;     // word i = base + i*step
        logic [31:0] step;
        int          glitch;   // word index that also pulses I_start (-1 = none)
        int          exp_n;    // words expected written and read back
    } vec_t;

    task automatic check_idle(input string tag);
        check({tag, "_sready"},   32'(O_sready),   0);
        check({tag, "_mvalid"},   32'(O_mvalid),   0);
        check({tag, "_busy"},     32'(O_busy),     0);
        check({tag, "_done"},     32'(O_done),     0);
        check({tag, "_ram_wr"},   32'(O_ram_wr),   0);
        check({tag, "_ram_addr"}, 32'(O_ram_addr), 0);
        check({tag, "_mdata"},    O_mdata,         0);
    endtask

    task automatic send_burst(input vec_t v, input string tag);
        int waited, gaps;
        mready_pct = v.pct;
        I_len   = v.len[ASIZE:0];
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
        for (int i = 0; i < v.exp_n; i++) begin
            gaps = (v.gap_max > 0) ? int'($urandom_range(v.gap_max, 1)) : 0;
            I_svalid = 1'b0;
            repeat (gaps) tick();
            I_svalid = 1'b1;
            I_sdata  = v.base + 32'(i) * v.step;
            if (i == v.glitch) begin
                I_start = 1'b1;
                I_len   = 1;
            end
            waited = 0;
            while (!O_sready && waited < 50) begin tick(); waited++; end
            if (!O_sready) begin
                check({tag, "_sready_timeout"}, 32'(O_sready), 1);
                break;
            end
            tick();
            I_start = 1'b0;
        end
        I_svalid = 1'b0;
        I_start  = 1'b0;
    endtask

    task automatic finish_burst(input vec_t v, input string tag);
        int waited, errs;
        logic [31:0] want;
        waited = 0;
        while (!O_done && waited < 300) begin tick(); waited++; end
        if (!O_done) begin
            check({tag, "_done_timeout"}, 32'(O_done), 1);
            return;
        end
        tick();
        check({tag, "_busy_after_done"}, 32'(O_busy), 0);
        check({tag, "_done_one_cycle"},  32'(O_done), 0);

        check({tag, "_n_writes"}, 32'(wr_addr_q.size()), 32'(v.exp_n));
        errs = 0;
        for (int i = 0; i < wr_addr_q.size() && i < v.exp_n; i++) begin
            want = v.base + 32'(i) * v.step;
            if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== want) errs++;
        end
        check({tag, "_write_errs"}, 32'(errs), 0);

        check({tag, "_n_pops"}, 32'(pop_q.size()), 32'(v.exp_n));
        errs = 0;
        for (int i = 0; i < pop_q.size() && i < v.exp_n; i++) begin
            want = v.base + 32'(i) * v.step;
            if (pop_q[i] !== want) errs++;
        end
        check({tag, "_pop_errs"}, 32'(errs), 0);

        check({tag, "_wr_without_valid"}, 32'(bad_wr),    0);
        check({tag, "_stall_unstable"},   32'(bad_stall), 0);
        check({tag, "_valid_ready_idle"}, 32'(bad_idle),  0);
        check({tag, "_done_pulses"},      32'(done_cnt),  1);

        if (v.exp_n == 0) begin
            check({tag, "_done_latency"}, 32'(done_cyc - start_cyc), 1);
            check({tag, "_no_mvalid"},    32'(first_mv_cyc), 32'hFFFF_FFFF);
        end else begin
            check({tag, "_first_mvalid_lat"}, 32'(first_mv_cyc - last_wr_cyc), 3);
            check({tag, "_done_after_pop"},   32'(done_cyc - last_pop_cyc), 1);
            if (v.pct == 100)
                check({tag, "_pop_span"}, 32'(last_pop_cyc - first_pop_cyc), 32'(v.exp_n - 1));
        end
    endtask

    vec_t vecs[7];
    vec_t v_mid, v_post;

    initial begin
        //           len gap pct  base           step         glitch exp_n
        vecs[0] = '{ 4,  0, 100, 32'h0000_0011, 32'h0000_0011, -1,  4 };
        vecs[1] = '{ 8,  0,  50, 32'h0000_00A0, 32'h0000_0001, -1,  8 };
        vecs[2] = '{16,  0, 100, 32'h0000_1000, 32'h0000_0101, -1, 16 };
        vecs[3] = '{20,  0, 100, 32'h0000_2000, 32'h0000_0003, -1, 16 };
        vecs[4] = '{ 5,  3, 100, 32'h0000_0500, 32'h0000_0007, -1,  5 };
        vecs[5] = '{ 0,  0, 100, 32'h0000_0000, 32'h0000_0000, -1,  0 };
        vecs[6] = '{ 3,  0,  50, 32'h0000_0300, 32'h0000_0010,  1,  3 };
        v_mid   = '{ 6,  0,   0, 32'h0000_0600, 32'h0000_0001, -1,  6 };
        v_post  = '{ 3,  0, 100, 32'h0000_0700, 32'h0000_0002, -1,  3 };

        I_rst = 1'b1; I_start = 1'b0; I_len = '0; I_sdata = '0;
        I_svalid = 1'b0; I_mready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        I_rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) begin
            send_burst(vecs[k], $sformatf("v%0d", k));
            finish_burst(vecs[k], $sformatf("v%0d", k));
            tick();
        end

        // Reset while reading: two of six words consumed, rest lost.
        begin
            int waited;
            send_burst(v_mid, "midrst");
            waited = 0;
            while (!O_mvalid && waited < 20) begin tick(); waited++; end
            if (!O_mvalid) check("midrst_mvalid_timeout", 32'(O_mvalid), 1);
            I_mready   = 1'b1;
            mready_pct = 100;
            tick();
            tick();
            mready_pct = 0;
            I_mready   = 1'b0;
            I_rst      = 1'b1;
            tick();
            check_idle("midrst");
            check("midrst_n_pops", 32'(pop_q.size()), 2);
            if (pop_q.size() >= 2) begin
                check("midrst_pop0", pop_q[0], 32'h0000_0600);
                check("midrst_pop1", pop_q[1], 32'h0000_0601);
            end
            check("midrst_no_done", 32'(done_cnt), 0);
            I_rst = 1'b0;
            tick();
            send_burst(v_post, "postrst");
            finish_burst(v_post, "postrst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
